// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use hazard detector and stall sequencer.
// Holds PC and IF/ID and bubbles ID/EX for STALL_CYCLES cycles per load-use
// event, never flags $zero, and keeps a saturating hazard event counter.
// Optional macro HAZARD_BRANCH_EN adds one-cycle stalls for BEQ/BNE operands
// still being produced in EX (ALU result) or MEM (load).
module hazard_stall_unit #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned HCNT_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            opCode,
    input  logic [REG_ADDR_W-1:0] rsIFID,
    input  logic [REG_ADDR_W-1:0] rtIFID,
    input  logic                  useRs,
    input  logic                  useRt,
    input  logic [REG_ADDR_W-1:0] rtIDEX,
    input  logic                  memRead,
    input  logic                  regWriteIDEX,
    input  logic [REG_ADDR_W-1:0] rdIDEX,
    input  logic                  memReadEXMEM,
    input  logic [REG_ADDR_W-1:0] rtEXMEM,
    output logic                  stall,
    output logic                  pcWrite,
    output logic                  ifidWrite,
    output logic                  idexFlush,
    output logic [HCNT_W-1:0]     hazardCount
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int unsigned      CNT_W    = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               MULTI    = (STALL_CYCLES > 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [5:0]       OP_BEQ   = 6'b000100;
    localparam logic [5:0]       OP_BNE   = 6'b000101;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HCNT_W-1:0]  hcnt_q, hcnt_d;

    logic load_hit_c;
    logic br_hit_c;
    logic event_c;
    logic stall_c;

    // Load in EX whose destination is a source actually read by ID ($zero excluded)
    always_comb begin
        load_hit_c = memRead && (rtIDEX != '0) &&
                     ((useRs && (rsIFID == rtIDEX)) || (useRt && (rtIFID == rtIDEX)));
    end

`ifdef HAZARD_BRANCH_EN
    logic is_branch_c;
    logic ex_hit_c;
    logic mem_hit_c;

    // Branch compares in ID need operands still in flight in EX or MEM
    always_comb begin
        is_branch_c = (opCode == OP_BEQ) || (opCode == OP_BNE);
        ex_hit_c    = regWriteIDEX && (rdIDEX != '0) &&
                      ((useRs && (rsIFID == rdIDEX)) || (useRt && (rtIFID == rdIDEX)));
        mem_hit_c   = memReadEXMEM && (rtEXMEM != '0) &&
                      ((useRs && (rsIFID == rtEXMEM)) || (useRt && (rtIFID == rtEXMEM)));
        br_hit_c    = is_branch_c && (ex_hit_c || mem_hit_c);
    end
`else
    logic unused_branch_c;

    // Branch ports have no function without the branch feature
    always_comb begin
        br_hit_c        = 1'b0;
        unused_branch_c = ^{opCode, regWriteIDEX, rdIDEX, memReadEXMEM, rtEXMEM};
    end
`endif

    // Next-state, remaining-cycle and event-counter logic; stall decoded same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        stall_c = 1'b0;
        event_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_hit_c) begin
                    stall_c = 1'b1;
                    event_c = 1'b1;
                    if (MULTI) begin
                        state_d = HOLD;
                        cnt_d   = CNT_LOAD;
                    end
                end else if (br_hit_c) begin
                    stall_c = 1'b1;
                    event_c = 1'b1;
                end
            end
            HOLD: begin
                stall_c = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (event_c && (hcnt_q != HCNT_MAX)) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
        end

        // Reset forces the pipeline to run freely in the same cycle
        if (reset) begin
            stall_c = 1'b0;
        end
    end

    // State, remaining-cycle counter and event counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign stall       = stall_c;
    assign pcWrite     = ~stall_c;
    assign ifidWrite   = ~stall_c;
    assign idexFlush   = stall_c;
    assign hazardCount = hcnt_q;

endmodule
